// File: rtl/ascon_pack.sv
// Shared types, widths and round primitives for the Ascon permutation core.
package ascon_pack;

    localparam int unsigned WORD_W       = 64;
    localparam int unsigned NUM_WORDS    = 5;
    localparam int unsigned ROUND_W      = 4;
    localparam int unsigned ROUNDS_TOTAL = 12;
    localparam int unsigned LAST_ROUND   = 11;
    localparam int unsigned ROUNDS_A_DEF = 12;
    localparam int unsigned ROUNDS_B_DEF = 6;

    // Word 0 is x0 (S-box column MSB), word 4 is x4 (column LSB).
    typedef logic [NUM_WORDS-1:0][WORD_W-1:0] type_state;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_RUN  = 2'd1,
        FSM_DONE = 2'd2
    } type_fsm;

    function automatic logic [4:0] sbox(input logic [4:0] x);
        logic [4:0] y;
        y = 5'h00;
        case (x)
            5'd0:  y = 5'h04;  5'd1:  y = 5'h0b;  5'd2:  y = 5'h1f;  5'd3:  y = 5'h14;
            5'd4:  y = 5'h1a;  5'd5:  y = 5'h15;  5'd6:  y = 5'h09;  5'd7:  y = 5'h02;
            5'd8:  y = 5'h1b;  5'd9:  y = 5'h05;  5'd10: y = 5'h08;  5'd11: y = 5'h12;
            5'd12: y = 5'h1d;  5'd13: y = 5'h03;  5'd14: y = 5'h06;  5'd15: y = 5'h1c;
            5'd16: y = 5'h1e;  5'd17: y = 5'h13;  5'd18: y = 5'h07;  5'd19: y = 5'h0e;
            5'd20: y = 5'h00;  5'd21: y = 5'h0d;  5'd22: y = 5'h11;  5'd23: y = 5'h18;
            5'd24: y = 5'h10;  5'd25: y = 5'h0c;  5'd26: y = 5'h01;  5'd27: y = 5'h19;
            5'd28: y = 5'h16;  5'd29: y = 5'h0a;  5'd30: y = 5'h0f;  5'd31: y = 5'h17;
        endcase
        return y;
    endfunction

    // c_r = {15 - r, r}: 0xF0 at r=0 down to 0x4B at r=11.
    function automatic logic [7:0] round_const(input logic [ROUND_W-1:0] r);
        return {4'(4'd15 - r), r};
    endfunction

    function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

endpackage

// File: rtl/ascon_round_engine_if.sv
// Start/done handshake and state bus between the Ascon control FSM and the round engine.
interface ascon_round_engine_if;
    import ascon_pack::*;

    logic                 start_i;
    logic                 mode_i;
    type_state            state_i;
    type_state            state_o;
    logic                 busy_o;
    logic                 done_o;
    logic [ROUND_W-1:0]   round_o;

    modport slave (
        input  start_i, mode_i, state_i,
        output state_o, busy_o, done_o, round_o
    );

    modport master (
        output start_i, mode_i, state_i,
        input  state_o, busy_o, done_o, round_o
    );
endinterface

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, bitsliced S-box, linear diffusion.
module ascon_round
    import ascon_pack::*;
(
    input  type_state            state_i,
    input  logic [ROUND_W-1:0]   round_i,
    output type_state            state_o
);

    type_state s_add;
    type_state s_sub;
    type_state s_lin;

    always_comb begin
        s_add    = state_i;
        s_add[2] = state_i[2] ^ {56'b0, round_const(round_i)};
    end

    // Each of the 64 columns is one 5-bit S-box lookup, x0 as MSB.
    always_comb begin
        s_sub = '0;
        for (int i = 0; i < int'(WORD_W); i++) begin
            {s_sub[0][i], s_sub[1][i], s_sub[2][i], s_sub[3][i], s_sub[4][i]} =
                sbox({s_add[0][i], s_add[1][i], s_add[2][i], s_add[3][i], s_add[4][i]});
        end
    end

    always_comb begin
        s_lin    = '0;
        s_lin[0] = s_sub[0] ^ ror(s_sub[0], 19) ^ ror(s_sub[0], 28);
        s_lin[1] = s_sub[1] ^ ror(s_sub[1], 61) ^ ror(s_sub[1], 39);
        s_lin[2] = s_sub[2] ^ ror(s_sub[2], 1)  ^ ror(s_sub[2], 6);
        s_lin[3] = s_sub[3] ^ ror(s_sub[3], 10) ^ ror(s_sub[3], 17);
        s_lin[4] = s_sub[4] ^ ror(s_sub[4], 7)  ^ ror(s_sub[4], 41);
    end

    assign state_o = s_lin;

endmodule

// File: rtl/ascon_round_engine.sv
// Iterative Ascon permutation: one round per clock over a 320-bit state, pa or pb per request.
module ascon_round_engine
    import ascon_pack::*;
#(
    parameter int unsigned ROUNDS_A = ROUNDS_A_DEF,
    parameter int unsigned ROUNDS_B = ROUNDS_B_DEF
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    ascon_round_engine_if.slave   bus
);

    // Shorter permutations run the tail of the 12-round constant schedule.
    localparam logic [ROUND_W-1:0] START_A = ROUND_W'(ROUNDS_TOTAL - ROUNDS_A);
    localparam logic [ROUND_W-1:0] START_B = ROUND_W'(ROUNDS_TOTAL - ROUNDS_B);
    localparam logic [ROUND_W-1:0] LAST_R  = ROUND_W'(LAST_ROUND);

    type_fsm              fsm_q;
    type_state            state_q;
    type_state            round_out;
    logic [ROUND_W-1:0]   round_q;
    logic                 busy_q;
    logic                 done_q;

    ascon_round u_round (
        .state_i (state_q),
        .round_i (round_q),
        .state_o (round_out)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_q   <= FSM_IDLE;
            state_q <= '0;
            round_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                FSM_IDLE: begin
                    if (bus.start_i) begin
                        state_q <= bus.state_i;
                        round_q <= bus.mode_i ? START_B : START_A;
                        busy_q  <= 1'b1;
                        fsm_q   <= FSM_RUN;
                    end
                end
                FSM_RUN: begin
                    state_q <= round_out;
                    if (round_q == LAST_R) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        fsm_q  <= FSM_DONE;
                    end else begin
                        round_q <= round_q + ROUND_W'(1);
                    end
                end
                FSM_DONE: begin
                    round_q <= '0;
                    fsm_q   <= FSM_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    fsm_q  <= FSM_IDLE;
                end
            endcase
        end
    end

    assign bus.state_o = state_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
    assign bus.round_o = round_q;

endmodule

// File: tb/tb_ascon_round_engine.sv
// Scoreboard bench for ascon_round_engine: stimulus queues expected results, a monitor checks them.
module tb_ascon_round_engine;
    import ascon_pack::*;

    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    ascon_round_engine_if bus ();

    ascon_round_engine #(.ROUNDS_A(12), .ROUNDS_B(6)) u_dut (
        .clock_i (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    type_state   rt_state;
    logic [3:0]  rt_round;
    type_state   rt_out;

    ascon_round u_round_direct (
        .state_i (rt_state),
        .round_i (rt_round),
        .state_o (rt_out)
    );

    typedef struct {
        type_state   exp;
        int          start;
        int          rounds;
        logic [3:0]  first;
    } sb_t;

    sb_t       sb[$];
    int        tests = 0;
    int        fails = 0;
    int        cyc   = 0;
    int        k;
    type_state last_exp;
    type_state iv_state;
    type_state alt_state;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string name, input type_state act, input type_state exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference round written from the bitsliced reference implementation.
    function automatic logic [63:0] rot_r(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic type_state model_round(input type_state s, input int r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
        x2 = x2 ^ 64'(((15 - r) << 4) | r);
        x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
        x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
        x0 = x0 ^ rot_r(x0, 19) ^ rot_r(x0, 28);
        x1 = x1 ^ rot_r(x1, 61) ^ rot_r(x1, 39);
        x2 = x2 ^ rot_r(x2, 1)  ^ rot_r(x2, 6);
        x3 = x3 ^ rot_r(x3, 10) ^ rot_r(x3, 17);
        x4 = x4 ^ rot_r(x4, 7)  ^ rot_r(x4, 41);
        return {x4, x3, x2, x1, x0};
    endfunction

    function automatic type_state model_perm(input type_state s, input int rounds);
        type_state t;
        t = s;
        for (int r = 12 - rounds; r < 12; r++) t = model_round(t, r);
        return t;
    endfunction

    function automatic sb_t make_entry(input type_state s, input logic mode, input int start);
        sb_t e;
        e.rounds = mode ? 6 : 12;
        e.first  = mode ? 4'd6 : 4'd0;
        e.exp    = model_perm(s, e.rounds);
        e.start  = start;
        return e;
    endfunction

    // Monitor: idle outside a pending permutation, per-round progress, final state on done.
    always @(negedge clk) begin
        if (!reset_i) begin
            if (sb.size() == 0 || cyc < sb[0].start) begin
                chk("idle_busy", 64'(bus.busy_o), 64'd0);
                chk("idle_done", 64'(bus.done_o), 64'd0);
            end else begin
                k = cyc - sb[0].start;
                if (k < sb[0].rounds) begin
                    chk("run_busy",  64'(bus.busy_o), 64'd1);
                    chk("run_done",  64'(bus.done_o), 64'd0);
                    chk("run_round", 64'(bus.round_o), 64'(sb[0].first + 4'(k)));
                end else begin
                    chk("done_pulse", 64'(bus.done_o), 64'd1);
                    chk("done_busy",  64'(bus.busy_o), 64'd0);
                    chk("done_round", 64'(bus.round_o), 64'd11);
                    chk_state("done_state", bus.state_o, sb[0].exp);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic issue(input type_state s, input logic mode);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.mode_i  = mode;
        bus.state_i = s;
        @(posedge clk);
        #1;
        sb.push_back(make_entry(s, mode, cyc));
        last_exp = sb[$].exp;
        bus.start_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        repeat (3) @(negedge clk);
        chk_state("state_hold", bus.state_o, last_exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int s;
        iv_state  = {64'h08090A0B0C0D0E0F, 64'h0001020304050607,
                     64'h08090A0B0C0D0E0F, 64'h0001020304050607,
                     64'h80400C0600000000};
        alt_state = {64'h1111111111111111, 64'h2222222222222222,
                     64'h3333333333333333, 64'h4444444444444444,
                     64'h5555555555555555};
        reset_i     = 1'b1;
        bus.start_i = 1'b0;
        bus.mode_i  = 1'b0;
        bus.state_i = '0;
        rt_state    = '0;
        rt_round    = 4'd0;

        repeat (3) @(posedge clk);
        #1;
        chk_state("rst_state", bus.state_o, '0);
        chk("rst_busy",  64'(bus.busy_o), 64'd0);
        chk("rst_done",  64'(bus.done_o), 64'd0);
        chk("rst_round", 64'(bus.round_o), 64'd0);
        @(negedge clk);
        reset_i = 1'b0;

        // Idle after reset with no request.
        repeat (20) begin
            @(negedge clk);
            chk_state("idle_state", bus.state_o, '0);
            chk("idle_round", 64'(bus.round_o), 64'd0);
        end

        // Single round on zero state at r=0, hand-derived.
        #1;
        chk("rnd0_x0", rt_out[0], 64'h001E0F00000000F0);
        chk("rnd0_x1", rt_out[1], 64'h00000001E0000770);
        chk("rnd0_x2", rt_out[2], 64'h3FFFFFFFFFFFFF74);
        chk("rnd0_x3", rt_out[3], 64'h3C780000000000F0);
        chk("rnd0_x4", rt_out[4], 64'h0000000000000000);
        rt_state = iv_state;
        rt_round = 4'd5;
        #1;
        chk_state("rnd5_iv", rt_out, model_round(iv_state, 5));

        // pa then pb on the Ascon-128 initial state.
        issue(iv_state, 1'b0);
        drain();
        issue(iv_state, 1'b1);
        drain();

        // start_i held high across a run; state_i changes mid-run.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.mode_i  = 1'b0;
        bus.state_i = iv_state;
        @(posedge clk);
        #1;
        s = cyc;
        sb.push_back(make_entry(iv_state, 1'b0, s));
        repeat (5) @(posedge clk);
        #1;
        bus.state_i = alt_state;
        sb.push_back(make_entry(alt_state, 1'b0, s + 14));
        last_exp = sb[$].exp;
        repeat (9) @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        drain();

        // Asynchronous reset in the middle of pa.
        issue(iv_state, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        chk("pre_rst_round", 64'(bus.round_o), 64'd5);
        reset_i = 1'b1;
        sb.delete();
        #1;
        chk_state("async_rst_state", bus.state_o, '0);
        chk("async_rst_busy",  64'(bus.busy_o), 64'd0);
        chk("async_rst_done",  64'(bus.done_o), 64'd0);
        chk("async_rst_round", 64'(bus.round_o), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        issue(iv_state, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
